// File: rtl/concat_arbiter.sv
// rtl/concat_arbiter.sv - write/read burst arbiter for concatenation layers
// Rotating write grant from layer_ptr; reads strictly in layer order.
module concat_arbiter #(
   parameter int                    N_CH      = 5,
   parameter int                    CNT_W     = 8,
   parameter logic [N_CH*CNT_W-1:0] BURST_LEN = {8'd112, 8'd112, 8'd112, 8'd112, 8'd224}
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic [N_CH-1:0]           req_wr,
   input  logic [N_CH-1:0]           req_rd,
   output logic [N_CH-1:0]           wr_en,
   output logic [N_CH-1:0]           rd_en,
   output logic                      wr_done,
   output logic                      rd_done,
   output logic [$clog2(N_CH)-1:0]   layer_ptr
);

   localparam int PTR_W = $clog2(N_CH);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_ARB   = 3'd1,
      WR_BURST = 3'd2,
      RD_ARB   = 3'd3,
      RD_BURST = 3'd4
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [PTR_W-1:0]   grant;
   logic [PTR_W-1:0]   wr_pick;
   logic               wr_any;
   logic               last;
   logic [CNT_W-1:0]   len_tab [N_CH];
   logic [CNT_W-1:0]   cur_len;
   logic [N_CH-1:0]    grant_onehot;

   for (genvar g = 0; g < N_CH; g++) begin : g_len
      assign len_tab[g] = BURST_LEN[g*CNT_W +: CNT_W];
   end

   assign cur_len      = len_tab[grant];
   assign last         = (cnt == cur_len - CNT_W'(1));
   assign grant_onehot = N_CH'(1) << grant;

   // Scan offsets high-to-low so the smallest offset from layer_ptr wins.
   always_comb begin
      int idx;
      wr_pick = layer_ptr;
      wr_any  = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         idx = int'(layer_ptr) + i;
         if (idx >= N_CH) idx = idx - N_CH;
         if (req_wr[PTR_W'(idx)]) begin
            wr_pick = PTR_W'(idx);
            wr_any  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     state_nx = WR_ARB;
         WR_ARB:   state_nx = wr_any ? WR_BURST : RD_ARB;
         WR_BURST: if (last) state_nx = RD_ARB;
         RD_ARB:   state_nx = req_rd[layer_ptr] ? RD_BURST : WR_ARB;
         RD_BURST: if (last) state_nx = WR_ARB;
         default:  state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_comb begin
      wr_en = '0;
      rd_en = '0;
      if (state == WR_BURST) wr_en = grant_onehot;
      if (state == RD_BURST) rd_en = grant_onehot;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         grant     <= '0;
         layer_ptr <= '0;
         wr_done   <= 1'b0;
         rd_done   <= 1'b0;
      end else if (flush) begin
         cnt       <= '0;
         grant     <= '0;
         layer_ptr <= '0;
         wr_done   <= 1'b0;
         rd_done   <= 1'b0;
      end else begin
         wr_done <= 1'b0;
         rd_done <= 1'b0;
         case (state)
            WR_ARB: begin
               cnt <= '0;
               if (wr_any) grant <= wr_pick;
            end
            RD_ARB: begin
               cnt <= '0;
               if (req_rd[layer_ptr]) grant <= layer_ptr;
            end
            WR_BURST: begin
               if (last) begin
                  cnt     <= '0;
                  wr_done <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RD_BURST: begin
               if (last) begin
                  cnt     <= '0;
                  rd_done <= 1'b1;
                  if (layer_ptr == PTR_W'(N_CH - 1)) layer_ptr <= '0;
                  else                               layer_ptr <= layer_ptr + PTR_W'(1);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_concat_arbiter.sv
// tb/tb_concat_arbiter.sv - scoreboard bench for concat_arbiter
// Expected bursts are queued with the stimulus and popped when a strobe run ends.
module tb_concat_arbiter;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       flush;
   logic [4:0] req_wr, req_rd, m_wr_en, m_rd_en;
   logic       m_wr_done, m_rd_done;
   logic [2:0] m_ptr;

   logic       s_flush;
   logic [2:0] s_req_wr, s_req_rd, s_wr_en, s_rd_en;
   logic       s_wr_done, s_rd_done;
   logic [1:0] s_ptr;

   concat_arbiter dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .req_wr(req_wr), .req_rd(req_rd),
      .wr_en(m_wr_en), .rd_en(m_rd_en),
      .wr_done(m_wr_done), .rd_done(m_rd_done),
      .layer_ptr(m_ptr)
   );

   concat_arbiter #(.N_CH(3), .CNT_W(8), .BURST_LEN({8'd1, 8'd2, 8'd3})) dut_small (
      .clk(clk), .reset_n(reset_n), .flush(s_flush),
      .req_wr(s_req_wr), .req_rd(s_req_rd),
      .wr_en(s_wr_en), .rd_en(s_rd_en),
      .wr_done(s_wr_done), .rd_done(s_rd_done),
      .layer_ptr(s_ptr)
   );

   typedef struct {
      bit wr;
      int ch;
      int len;
      bit done;
   } burst_t;

   burst_t q_main[$];
   burst_t q_small[$];

   int errors = 0, checks = 0;
   int excl_viol = 0, onehot_viol = 0, chg_viol = 0, stray_done = 0;
   int extra_bursts = 0, idle_strobes = 0;
   bit idle_mon = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int first_bit(input logic [4:0] v);
      for (int i = 0; i < 5; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic void push_m(input bit wr, input int ch, input int len, input bit done);
      burst_t e;
      e.wr = wr; e.ch = ch; e.len = len; e.done = done;
      q_main.push_back(e);
   endfunction

   // Main DUT monitor
   int m_len = 0;
   bit m_kind;
   int m_ch;
   always @(negedge clk) begin
      logic [4:0] s;
      burst_t     e;
      s = m_wr_en | m_rd_en;
      if (m_wr_en != 0 && m_rd_en != 0) excl_viol++;
      if (idle_mon && s != 0) idle_strobes++;
      if (s != 0) begin
         if ($countones(s) != 1) onehot_viol++;
         if (m_len == 0) begin
            m_kind = (m_wr_en != 0);
            m_ch   = first_bit(s);
         end else if (m_kind != (m_wr_en != 0) || m_ch != first_bit(s)) begin
            chg_viol++;
         end
         m_len++;
         if (m_wr_done || m_rd_done) stray_done++;
      end else if (m_len != 0) begin
         if (q_main.size() == 0) extra_bursts++;
         else begin
            e = q_main.pop_front();
            check("main_kind", m_kind, e.wr);
            check("main_ch", m_ch, e.ch);
            check("main_len", m_len, e.len);
            check("main_wr_done", m_wr_done, e.wr & e.done);
            check("main_rd_done", m_rd_done, !e.wr & e.done);
         end
         m_len = 0;
      end else if (m_wr_done || m_rd_done) begin
         stray_done++;
      end
   end

   // Small DUT monitor; bursts after the expected list is drained are ignored
   int s_len = 0;
   bit s_kind;
   int s_ch;
   always @(negedge clk) begin
      logic [4:0] s;
      burst_t     e;
      s = {2'b00, s_wr_en | s_rd_en};
      if (s_wr_en != 0 && s_rd_en != 0) excl_viol++;
      if (s != 0) begin
         if ($countones(s) != 1) onehot_viol++;
         if (s_len == 0) begin
            s_kind = (s_wr_en != 0);
            s_ch   = first_bit(s);
         end else if (s_kind != (s_wr_en != 0) || s_ch != first_bit(s)) begin
            chg_viol++;
         end
         s_len++;
         if (s_wr_done || s_rd_done) stray_done++;
      end else if (s_len != 0) begin
         if (q_small.size() != 0) begin
            e = q_small.pop_front();
            check("small_kind", s_kind, e.wr);
            check("small_ch", s_ch, e.ch);
            check("small_len", s_len, e.len);
            check("small_wr_done", s_wr_done, e.wr & e.done);
            check("small_rd_done", s_rd_done, !e.wr & e.done);
         end
         s_len = 0;
      end else if (s_wr_done || s_rd_done) begin
         stray_done++;
      end
   end

   task automatic wait_beat(input bit wr, input int ch, input int limit);
      bit hit = 0;
      for (int i = 0; i < limit && !hit; i++) begin
         @(negedge clk);
         hit = wr ? m_wr_en[ch] : m_rd_en[ch];
      end
      check($sformatf("wait_beat_%s%0d", wr ? "wr" : "rd", ch), hit, 1);
   endtask

   task automatic wait_drain(input int limit);
      for (int i = 0; i < limit && q_main.size() != 0; i++) @(negedge clk);
      check("sb_drain", q_main.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      burst_t e;
      reset_n  = 1'b0;
      flush    = 1'b0;
      s_flush  = 1'b0;
      req_wr   = '0;
      req_rd   = '0;
      s_req_wr = 3'b111;
      s_req_rd = 3'b111;
      repeat (3) @(negedge clk);
      check("rst_wr_en", m_wr_en, 0);
      check("rst_rd_en", m_rd_en, 0);
      check("rst_done", {m_wr_done, m_rd_done}, 0);
      check("rst_ptr", m_ptr, 0);

      for (int r = 0; r < 2; r++)
         for (int ch = 0; ch < 3; ch++) begin
            e.ch = ch; e.len = 3 - ch; e.done = 1;
            e.wr = 1; q_small.push_back(e);
            e.wr = 0; q_small.push_back(e);
         end

      // Single ch0 write straight after reset release
      req_wr = 5'b00001;
      push_m(1, 0, 224, 1);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("first_beat_early", m_wr_en, 0);
      @(negedge clk);
      check("first_beat", m_wr_en, 5'b00001);
      req_wr = '0;
      wait_drain(300);
      check("small_drain", q_small.size(), 0);

      // All reads held: layers in order, pointer wraps
      for (int ch = 0; ch < 5; ch++) push_m(0, ch, (ch == 0) ? 224 : 112, 1);
      req_rd = 5'b11111;
      wait_beat(0, 4, 1500);
      req_rd = '0;
      wait_drain(300);
      check("ptr_wrap", m_ptr, 0);

      // Rotation from layer_ptr=2 and write-before-read on the same channel
      push_m(0, 0, 224, 1);
      push_m(0, 1, 112, 1);
      push_m(1, 4, 112, 1);
      push_m(1, 1, 112, 1);
      push_m(0, 2, 112, 1);
      push_m(1, 3, 112, 1);
      push_m(0, 3, 112, 1);
      req_rd = 5'b00011;
      wait_beat(0, 1, 600);
      req_rd = '0;
      req_wr = 5'b10010;
      wait_beat(1, 4, 300);
      req_wr = 5'b00010;
      wait_beat(1, 1, 300);
      req_wr = '0;
      req_rd = 5'b00100;
      wait_beat(0, 2, 300);
      req_rd = 5'b01000;
      req_wr = 5'b01000;
      wait_beat(1, 3, 300);
      req_wr = '0;
      wait_beat(0, 3, 300);
      req_rd = '0;
      wait_drain(300);
      check("ptr_after_reads", m_ptr, 4);

      // Flush at beat 50 of a ch0 write, then restart via IDLE
      push_m(1, 0, 50, 0);
      push_m(1, 0, 224, 1);
      req_wr = 5'b00001;
      wait_beat(1, 0, 300);
      req_wr = '0;
      repeat (49) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      check("flush_strobe", m_wr_en, 0);
      check("flush_ptr", m_ptr, 0);
      flush  = 1'b0;
      req_wr = 5'b00001;
      @(negedge clk);
      check("restart_idle", m_wr_en, 0);
      @(negedge clk);
      check("restart_beat", m_wr_en, 5'b00001);
      req_wr = '0;
      wait_drain(300);

      // Read request off the pointer channel is never granted
      idle_mon = 1'b1;
      req_rd   = 5'b00010;
      repeat (40) @(negedge clk);
      idle_mon = 1'b0;
      req_rd   = '0;
      check("no_grant_strobes", idle_strobes, 0);
      check("no_grant_ptr", m_ptr, 0);

      // Asynchronous reset mid-burst: no done pulse
      push_m(1, 0, 10, 0);
      req_wr = 5'b00001;
      wait_beat(1, 0, 300);
      req_wr = '0;
      repeat (9) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_wr_en", m_wr_en, 0);
      check("async_rst_done", {m_wr_done, m_rd_done}, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wait_drain(10);
      repeat (5) @(negedge clk);

      check("strobe_exclusive", excl_viol, 0);
      check("strobe_onehot", onehot_viol, 0);
      check("strobe_steady", chg_viol, 0);
      check("stray_done", stray_done, 0);
      check("extra_bursts", extra_bursts, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
